// File: rtl/gt_rst_pkg.sv
// Shared types and helpers for the GT reset sequencer: state encoding,
// retry counter width and the shared down-counter width function.
package gt_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST     = 3'd0,
        WAIT_LOCK   = 3'd1,
        WAIT_USRCLK = 3'd2,
        DP_RST      = 3'd3,
        WAIT_DONE   = 3'd4,
        READY       = 3'd5,
        FAIL        = 3'd6
    } gt_rst_state_e;

    localparam int unsigned RETRY_CNT_W = 8;

    // Width needed to hold the largest of the three cycle counts.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gt_rst_sync.sv
// SYNC_STAGES-deep synchronizer for a single asynchronous level input,
// cleared asynchronously by rst.
module gt_rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gt_reset_sequencer.sv
// GT channel bring-up sequencer: PLL reset, lock, clock buffer release,
// datapath reset, reset-done, link_ready; retries on any timeout.
// Define GT_RST_SEQ_WATCHDOG_EN to leave READY on loss of lock or usrclk.
module gt_reset_sequencer
    import gt_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 64,
    parameter int unsigned DP_RST_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic                   usrclk_active,
    input  logic                   gt_reset_done,
    output logic                   pll_reset,
    output logic                   buf_rst,
    output logic                   gt_dp_reset,
    output logic                   link_ready,
    output logic [RETRY_CNT_W-1:0] retry_count
);

    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, DP_RST_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] PLL_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DP_LOAD  = CNT_W'(DP_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic pll_lock_s;
    logic usrclk_active_s;
    logic gt_reset_done_s;

    gt_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (pll_lock_s)
    );

    gt_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_usrclk (
        .clk (clk),
        .rst (rst),
        .d   (usrclk_active),
        .q   (usrclk_active_s)
    );

    gt_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
        .clk (clk),
        .rst (rst),
        .d   (gt_reset_done),
        .q   (gt_reset_done_s)
    );

    gt_rst_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d;
    logic                   boot_q, boot_d;
    logic                   pll_reset_q, pll_reset_d;
    logic                   buf_rst_q, buf_rst_d;
    logic                   gt_dp_reset_q, gt_dp_reset_d;
    logic                   link_ready_q, link_ready_d;

    logic [CNT_W-1:0]       cnt_eff;
    logic [CNT_W-1:0]       cnt_dec;
    logic                   cnt_done;

    // The counter resets to 0; boot_q stands in for the PLL_RST load on the
    // first cycle out of reset so the first attempt is as long as the retries.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        boot_d        = 1'b0;
        pll_reset_d   = 1'b1;
        buf_rst_d     = 1'b1;
        gt_dp_reset_d = 1'b1;
        link_ready_d  = 1'b0;
        cnt_eff       = boot_q ? PLL_LOAD : cnt_q;
        cnt_done      = (cnt_eff == '0);
        cnt_dec       = cnt_eff - CNT_W'(1);

        case (state_q)
            PLL_RST: begin
                if (cnt_done) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TO_LOAD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            WAIT_LOCK: begin
                if (pll_lock_s) begin
                    state_d = WAIT_USRCLK;
                    cnt_d   = TO_LOAD;
                end else if (cnt_done) begin
                    state_d = FAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            WAIT_USRCLK: begin
                if (usrclk_active_s) begin
                    state_d = DP_RST;
                    cnt_d   = DP_LOAD;
                end else if (!pll_lock_s || cnt_done) begin
                    state_d = FAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            DP_RST: begin
                if (cnt_done) begin
                    state_d = WAIT_DONE;
                    cnt_d   = TO_LOAD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            WAIT_DONE: begin
                if (gt_reset_done_s) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = FAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            READY: begin
`ifdef GT_RST_SEQ_WATCHDOG_EN
                if (!pll_lock_s || !usrclk_active_s) begin
                    state_d = FAIL;
                    cnt_d   = '0;
                end
`endif
            end
            FAIL: begin
                state_d = PLL_RST;
                cnt_d   = PLL_LOAD;
                if (retry_q != '1) begin
                    retry_d = retry_q + RETRY_CNT_W'(1);
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = PLL_LOAD;
            end
        endcase

        // Outputs follow the next state so they change with the state register.
        case (state_d)
            WAIT_LOCK: begin
                pll_reset_d = 1'b0;
            end
            WAIT_USRCLK, DP_RST: begin
                pll_reset_d = 1'b0;
                buf_rst_d   = 1'b0;
            end
            WAIT_DONE: begin
                pll_reset_d   = 1'b0;
                buf_rst_d     = 1'b0;
                gt_dp_reset_d = 1'b0;
            end
            READY: begin
                pll_reset_d   = 1'b0;
                buf_rst_d     = 1'b0;
                gt_dp_reset_d = 1'b0;
                link_ready_d  = 1'b1;
            end
            default: begin
                pll_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            boot_q        <= 1'b1;
            pll_reset_q   <= 1'b1;
            buf_rst_q     <= 1'b1;
            gt_dp_reset_q <= 1'b1;
            link_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            boot_q        <= boot_d;
            pll_reset_q   <= pll_reset_d;
            buf_rst_q     <= buf_rst_d;
            gt_dp_reset_q <= gt_dp_reset_d;
            link_ready_q  <= link_ready_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign buf_rst     = buf_rst_q;
    assign gt_dp_reset = gt_dp_reset_q;
    assign link_ready  = link_ready_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_gt_reset_sequencer.sv
// Self-checking bench for gt_reset_sequencer (small cycle counts); honours
// GT_RST_SEQ_WATCHDOG_EN for the READY-exit expectations.
module tb_gt_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       usrclk_active;
    logic       gt_reset_done;
    logic       pll_reset;
    logic       buf_rst;
    logic       gt_dp_reset;
    logic       link_ready;
    logic [7:0] retry_count;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    gt_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .DP_RST_CYCLES  (3),
        .TIMEOUT_CYCLES (50),
        .SYNC_STAGES    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .usrclk_active (usrclk_active),
        .gt_reset_done (gt_reset_done),
        .pll_reset     (pll_reset),
        .buf_rst       (buf_rst),
        .gt_dp_reset   (gt_dp_reset),
        .link_ready    (link_ready),
        .retry_count   (retry_count)
    );

    always #5 clk = ~clk;

    // Vector: inputs driven from the previous vector's cycle, outputs expected at .cycle.
    typedef struct {
        int         cycle;
        logic       lock;
        logic       usr;
        logic       done;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb_q[$];

    function automatic logic [11:0] pk(input bit p, input bit b, input bit d,
                                       input bit l, input int r);
        return {p, b, d, l, 8'(r)};
    endfunction

    function automatic logic [11:0] outs();
        return {pll_reset, buf_rst, gt_dp_reset, link_ready, retry_count};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick(2);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Bounded wait for buf_rst (sel 0) or gt_dp_reset (sel 1) to go low.
    task automatic wait_low(input int sel, input int max_cyc, input string nm);
        int i;
        logic v;
        i = 0;
        v = (sel == 0) ? buf_rst : gt_dp_reset;
        while (v !== 1'b0 && i < max_cyc) begin
            tick(1);
            i++;
            v = (sel == 0) ? buf_rst : gt_dp_reset;
        end
        chk(nm, 32'(v), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        pll_lock      = 1'b0;
        usrclk_active = 1'b0;
        gt_reset_done = 1'b0;

        // Nominal bring-up, then drop usrclk_active in READY.
        vecs.push_back('{0,  1'b0, 1'b0, 1'b0, pk(1, 1, 1, 0, 0)});
        vecs.push_back('{3,  1'b0, 1'b0, 1'b0, pk(1, 1, 1, 0, 0)});
        vecs.push_back('{4,  1'b0, 1'b0, 1'b0, pk(0, 1, 1, 0, 0)});
        vecs.push_back('{10, 1'b0, 1'b0, 1'b0, pk(0, 1, 1, 0, 0)});
        vecs.push_back('{12, 1'b1, 1'b0, 1'b0, pk(0, 1, 1, 0, 0)});
        vecs.push_back('{13, 1'b1, 1'b0, 1'b0, pk(0, 0, 1, 0, 0)});
        vecs.push_back('{20, 1'b1, 1'b0, 1'b0, pk(0, 0, 1, 0, 0)});
        vecs.push_back('{22, 1'b1, 1'b1, 1'b0, pk(0, 0, 1, 0, 0)});
        vecs.push_back('{25, 1'b1, 1'b1, 1'b0, pk(0, 0, 1, 0, 0)});
        vecs.push_back('{26, 1'b1, 1'b1, 1'b0, pk(0, 0, 0, 0, 0)});
        vecs.push_back('{40, 1'b1, 1'b1, 1'b0, pk(0, 0, 0, 0, 0)});
        vecs.push_back('{42, 1'b1, 1'b1, 1'b1, pk(0, 0, 0, 0, 0)});
        vecs.push_back('{43, 1'b1, 1'b1, 1'b1, pk(0, 0, 0, 1, 0)});
        vecs.push_back('{50, 1'b1, 1'b1, 1'b1, pk(0, 0, 0, 1, 0)});
        vecs.push_back('{52, 1'b1, 1'b0, 1'b1, pk(0, 0, 0, 1, 0)});
`ifdef GT_RST_SEQ_WATCHDOG_EN
        vecs.push_back('{53, 1'b1, 1'b0, 1'b1, pk(1, 1, 1, 0, 0)});
        vecs.push_back('{54, 1'b1, 1'b0, 1'b1, pk(1, 1, 1, 0, 1)});
`else
        vecs.push_back('{53, 1'b1, 1'b0, 1'b1, pk(0, 0, 0, 1, 0)});
        vecs.push_back('{60, 1'b1, 1'b0, 1'b1, pk(0, 0, 0, 1, 0)});
`endif

        do_reset();
        foreach (vecs[i]) begin
            pll_lock      = vecs[i].lock;
            usrclk_active = vecs[i].usr;
            gt_reset_done = vecs[i].done;
            sb_q.push_back(vecs[i].exp);
            tick(vecs[i].cycle - cyc);
            chk($sformatf("vec%0d_c%0d", i, vecs[i].cycle), 32'(outs()), 32'(sb_q.pop_front()));
        end

        // Lock timeout: one FAIL every 4+50+1 cycles, retry_count saturates.
        pll_lock      = 1'b0;
        usrclk_active = 1'b0;
        gt_reset_done = 1'b0;
        do_reset();
        tick(53);
        chk("lto_pll_low", 32'(pll_reset), 32'(0));
        tick(1);
        chk("lto_fail_pll", 32'(pll_reset), 32'(1));
        chk("lto_retry0", 32'(retry_count), 32'(0));
        for (int k = 1; k <= 300; k++) begin
            tick(55 * k - cyc);
            chk($sformatf("lto_retry_k%0d", k), 32'(retry_count), 32'((k > 255) ? 255 : k));
        end

        // Lost lock while waiting for usrclk_active.
        pll_lock = 1'b1;
        do_reset();
        wait_low(0, 20, "ll_reach_wait_usrclk");
        pll_lock = 1'b0;
        tick(2);
        chk("ll_buf_still_low", 32'(buf_rst), 32'(0));
        tick(1);
        chk("ll_buf_rst", 32'(buf_rst), 32'(1));
        tick(1);
        chk("ll_retry1", 32'(retry_count), 32'(1));
        chk("ll_pll_reset", 32'(pll_reset), 32'(1));

        // Mid-sequence reset during DP_RST (retry_count is 1 beforehand).
        pll_lock      = 1'b1;
        usrclk_active = 1'b1;
        wait_low(0, 20, "mr_reach_wait_usrclk");
        tick(1);
        chk("mr_pre", 32'(outs()), 32'(pk(0, 0, 1, 0, 1)));
        rst = 1'b1;
        #1;
        chk("mr_async", 32'(outs()), 32'(pk(1, 1, 1, 0, 0)));
        tick(2);
        rst = 1'b0;
        cyc = 0;
        tick(3);
        chk("mr_restart_pll_hi", 32'(pll_reset), 32'(1));
        tick(1);
        chk("mr_restart_pll_lo", 32'(pll_reset), 32'(0));

        // Reset-done synchronized value lands on the final timeout cycle.
        gt_reset_done = 1'b0;
        do_reset();
        wait_low(1, 40, "co_reach_wait_done");
        tick(47);
        gt_reset_done = 1'b1;
        tick(2);
        chk("co_link_pre", 32'(link_ready), 32'(0));
        tick(1);
        chk("co_link", 32'(link_ready), 32'(1));
        tick(5);
        chk("co_no_retry", 32'(outs()), 32'(pk(0, 0, 0, 1, 0)));

        // One cycle later than that: timeout wins.
        gt_reset_done = 1'b0;
        do_reset();
        wait_low(1, 40, "late_reach_wait_done");
        tick(48);
        gt_reset_done = 1'b1;
        tick(2);
        chk("late_fail", 32'(outs()), 32'(pk(1, 1, 1, 0, 0)));
        tick(1);
        chk("late_retry", 32'(retry_count), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
